// File: rtl/riscv_str_ops_unit.sv
// Multi-cycle string transform unit for the custom STR_OPS opcode.
// Walks a NUL-terminated string word by word: read, transform, write back.
module riscv_str_ops_unit #(
    parameter int LEN_WIDTH    = 16,
    parameter int STR_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [LEN_WIDTH-1:0]    result_o,
    output logic                    err_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic                    data_err_i,
    output logic [31:0]             data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_wdata_o,
    input  logic [31:0]             data_rdata_i
);

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 'd3;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t                  state;
    logic [STR_OP_WIDTH-1:0] op_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic                    term_q;

    logic [3:0]              be_n;
    logic [31:0]             wbuf_n;
    logic [2:0]              nbytes;
    logic [LEN_WIDTH-1:0]    cnt_n;
    logic                    term_n;

    function automatic logic [7:0] xform(
        input logic [STR_OP_WIDTH-1:0] op,
        input logic [7:0]              b
    );
        logic [7:0] r;
        r = b;
        case (op)
            STR_OP_UPPER: if (b >= 8'h61 && b <= 8'h7a) r = b - 8'h20;
            STR_OP_LOWER: if (b >= 8'h41 && b <= 8'h5a) r = b + 8'h20;
            // Folding to lowercase is safe: only letters collide with the keys.
            STR_OP_LEET: begin
                case (b | 8'h20)
                    8'h61:   r = 8'h34;
                    8'h65:   r = 8'h33;
                    8'h69:   r = 8'h31;
                    8'h6f:   r = 8'h30;
                    8'h73:   r = 8'h35;
                    8'h74:   r = 8'h37;
                    default: r = b;
                endcase
            end
            STR_OP_ROT13: begin
                if ((b >= 8'h61 && b <= 8'h6d) || (b >= 8'h41 && b <= 8'h4d))
                    r = b + 8'd13;
                else if ((b >= 8'h6e && b <= 8'h7a) || (b >= 8'h4e && b <= 8'h5a))
                    r = b - 8'd13;
            end
            default: r = b;
        endcase
        return r;
    endfunction

    // Bytes are taken in little-endian order until a NUL or the length limit.
    always_comb begin
        logic             stop;
        logic             nul_hit;
        logic [7:0]       b;
        logic [LEN_WIDTH:0] pos;
        be_n    = 4'b0000;
        wbuf_n  = data_rdata_i;
        nbytes  = 3'd0;
        stop    = 1'b0;
        nul_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b   = data_rdata_i[8*k +: 8];
            pos = {1'b0, result_o} + (LEN_WIDTH+1)'(k);
            if (!stop) begin
                if (b == 8'h00) begin
                    nul_hit = 1'b1;
                    stop    = 1'b1;
                end else if (pos >= {1'b0, len_q}) begin
                    stop = 1'b1;
                end else begin
                    be_n[k]         = 1'b1;
                    wbuf_n[8*k +: 8] = xform(op_q, b);
                    nbytes          = nbytes + 3'd1;
                end
            end
        end
        cnt_n  = result_o + LEN_WIDTH'(nbytes);
        term_n = nul_hit || (cnt_n == len_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            len_q        <= '0;
            term_q       <= 1'b0;
            ready_o      <= 1'b1;
            done_o       <= 1'b0;
            result_o     <= '0;
            err_o        <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= '0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        op_q        <= operator_i;
                        len_q       <= len_i;
                        data_addr_o <= {addr_i[31:2], 2'b00};
                        result_o    <= '0;
                        err_o       <= 1'b0;
                        ready_o     <= 1'b0;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (addr_i[1:0] != 2'b00) begin
                            err_o  <= 1'b1;
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= RD_REQ;
                            data_req_o <= 1'b1;
                            data_we_o  <= 1'b0;
                            data_be_o  <= 4'b1111;
                        end
                    end
                end
                RD_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_o  <= 1'b1;
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            result_o     <= cnt_n;
                            term_q       <= term_n;
                            data_be_o    <= be_n;
                            data_wdata_o <= wbuf_n;
                            if (be_n == 4'b0000) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state      <= WR_REQ;
                                data_req_o <= 1'b1;
                                data_we_o  <= 1'b1;
                            end
                        end
                    end
                end
                WR_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_o  <= 1'b1;
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (term_q) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            data_addr_o <= data_addr_o + 32'd4;
                            state       <= RD_REQ;
                            data_req_o  <= 1'b1;
                            data_we_o   <= 1'b0;
                            data_be_o   <= 4'b1111;
                        end
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    ready_o    <= 1'b1;
                    done_o     <= 1'b0;
                    data_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_str_ops_unit.sv
// Directed bench for riscv_str_ops_unit with a zero-wait memory model,
// optional grant stall and read-error injection.
module tb_riscv_str_ops_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [1:0]  operator_i = '0;
    logic [31:0] addr_i = '0;
    logic [15:0] len_i = '0;
    logic        ready_o, done_o, err_o;
    logic [15:0] result_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;

    always #5 clk = ~clk;

    riscv_str_ops_unit dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .operator_i    (operator_i),
        .addr_i        (addr_i),
        .len_i         (len_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .err_o         (err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_err_i    (data_err_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] wa_log [0:63];
    logic [3:0]  wbe_log [0:63];
    logic [31:0] wd_log [0:63];
    int stalled = 0, stall_cycles = 0, rd_n = 0, wr_n = 0, err_at = -1;
    int checks = 0, failures = 0;

    assign data_gnt_i = data_req_o && (stalled >= stall_cycles);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rvalid_i <= 1'b0;
            data_err_i    <= 1'b0;
            data_rdata_i  <= '0;
        end else begin
            data_rvalid_i <= 1'b0;
            data_err_i    <= 1'b0;
            if (data_req_o && !data_gnt_i) stalled <= stalled + 1;
            if (data_req_o && data_gnt_i) begin
                data_rvalid_i <= 1'b1;
                if (data_we_o) begin
                    wa_log[wr_n]  <= data_addr_o;
                    wbe_log[wr_n] <= data_be_o;
                    wd_log[wr_n]  <= data_wdata_o;
                    wr_n          <= wr_n + 1;
                end else begin
                    data_rdata_i <= mem[data_addr_o[11:2]];
                    data_err_i   <= (rd_n + 1 == err_at);
                    rd_n         <= rd_n + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [15:0] l);
        @(negedge clk);
        operator_i = op;
        addr_i     = a;
        len_i      = l;
        enable_i   = 1'b1;
        @(posedge clk);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", {31'd0, done_o}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [15:0] len;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wa;
        logic [3:0]  wbe;
        logic [31:0] wd;
    } vec_t;

    localparam int NV = 10;
    vec_t v [NV];

    initial begin
        int lat, rb, wb, hello_wb, n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[64]   = 32'h6C6C6568;
        mem[65]   = 32'h0000006F;
        mem[128]  = 32'h7A5A6241;
        mem[129]  = 32'h41414141;
        mem[192]  = 32'h74536554;
        mem[193]  = 32'h00000078;
        mem[256]  = 32'h405B5A41;
        mem[320]  = 32'h7B7A6160;
        mem[384]  = 32'h4E4D6E6D;
        mem[448]  = 32'h6F696561;
        mem[512]  = 32'h64636261;
        mem[513]  = 32'h41414141;
        mem[1023] = 32'h44434241;
        mem[0]    = 32'h00000065;

        v[0] = '{2'd0, 32'h100, 16'd16, 16'd5, 1'b0, 9, 2, 2, 32'h104, 4'h1, 32'h0000004F};
        v[1] = '{2'd3, 32'h200, 16'd4, 16'd4, 1'b0, 5, 1, 1, 32'h200, 4'hF, 32'h6D4D6F4E};
        v[2] = '{2'd2, 32'h300, 16'd3, 16'd3, 1'b0, 5, 1, 1, 32'h300, 4'h7, 32'h74353337};
        v[3] = '{2'd0, 32'h100, 16'd0, 16'd0, 1'b0, 1, 0, 0, 32'h0, 4'h0, 32'h0};
        v[4] = '{2'd0, 32'h102, 16'd8, 16'd0, 1'b1, 1, 0, 0, 32'h0, 4'h0, 32'h0};
        v[5] = '{2'd1, 32'h400, 16'd8, 16'd4, 1'b0, 7, 2, 1, 32'h400, 4'hF, 32'h405B7A61};
        v[6] = '{2'd0, 32'h500, 16'd4, 16'd4, 1'b0, 5, 1, 1, 32'h500, 4'hF, 32'h7B5A4160};
        v[7] = '{2'd3, 32'h600, 16'd4, 16'd4, 1'b0, 5, 1, 1, 32'h600, 4'hF, 32'h415A617A};
        v[8] = '{2'd2, 32'h700, 16'd2, 16'd2, 1'b0, 5, 1, 1, 32'h700, 4'h3, 32'h6F693334};
        v[9] = '{2'd1, 32'hFFFFFFFC, 16'd16, 16'd5, 1'b0, 9, 2, 2, 32'h0, 4'h1, 32'h00000065};

        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", {31'd0, ready_o}, 32'd1);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst req", {31'd0, data_req_o}, 32'd0);
        chk("rst we", {31'd0, data_we_o}, 32'd0);
        chk("rst err", {31'd0, err_o}, 32'd0);
        chk("rst result", {16'd0, result_o}, 32'd0);
        chk("rst addr", data_addr_o, 32'd0);
        chk("rst be", {28'd0, data_be_o}, 32'd0);
        chk("rst wdata", data_wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        hello_wb = 0;
        for (int i = 0; i < NV; i++) begin
            rb = rd_n;
            wb = wr_n;
            if (i == 0) hello_wb = wb;
            start(v[i].op, v[i].addr, v[i].len);
            wait_done(lat);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d result", i), {16'd0, result_o}, {16'd0, v[i].res});
            chk($sformatf("v%0d err", i), {31'd0, err_o}, {31'd0, v[i].err});
            chk($sformatf("v%0d reads", i), rd_n - rb, v[i].nrd);
            chk($sformatf("v%0d writes", i), wr_n - wb, v[i].nwr);
            if (v[i].nwr > 0 && wr_n > 0) begin
                chk($sformatf("v%0d waddr", i), wa_log[wr_n-1], v[i].wa);
                chk($sformatf("v%0d wbe", i), {28'd0, wbe_log[wr_n-1]}, {28'd0, v[i].wbe});
                chk($sformatf("v%0d wdata", i), wd_log[wr_n-1], v[i].wd);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse", i), {31'd0, done_o}, 32'd0);
            chk($sformatf("v%0d ready", i), {31'd0, ready_o}, 32'd1);
            chk($sformatf("v%0d hold result", i), {16'd0, result_o}, {16'd0, v[i].res});
        end
        chk("hello w0 addr", wa_log[hello_wb], 32'h100);
        chk("hello w0 be", {28'd0, wbe_log[hello_wb]}, 32'hF);
        chk("hello w0 data", wd_log[hello_wb], 32'h4C4C4548);

        // Grant stall on the first read, bus error on the second read.
        stall_cycles = 3;
        err_at       = rd_n + 2;
        wb           = wr_n;
        start(2'd0, 32'h800, 16'd16);
        for (int i = 0; i < 3; i++) begin
            enable_i   = 1'b1;
            operator_i = 2'd3;
            chk($sformatf("stall%0d req", i), {31'd0, data_req_o}, 32'd1);
            chk($sformatf("stall%0d addr", i), data_addr_o, 32'h800);
            chk($sformatf("stall%0d we", i), {31'd0, data_we_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        enable_i = 1'b0;
        wait_done(lat);
        chk("stall err", {31'd0, err_o}, 32'd1);
        chk("stall result", {16'd0, result_o}, 32'd4);
        chk("stall writes", wr_n - wb, 32'd1);
        chk("stall wdata", wd_log[wr_n-1], 32'h44434241);
        err_at = -1;
        @(posedge clk);
        #1;

        // Reset while a write request is pending.
        start(2'd0, 32'h100, 16'd16);
        n = 0;
        while (!(data_req_o && data_we_o) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid wr_req seen", {31'd0, data_req_o && data_we_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst req", {31'd0, data_req_o}, 32'd0);
        chk("mid rst ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wb  = wr_n;
        start(2'd3, 32'h200, 16'd4);
        wait_done(lat);
        chk("post rst result", {16'd0, result_o}, 32'd4);
        chk("post rst err", {31'd0, err_o}, 32'd0);
        chk("post rst writes", wr_n - wb, 32'd1);
        chk("post rst wdata", wd_log[wr_n-1], 32'h6D4D6F4E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
